wave_capture: RTL and testbench
===============================

Name: wave_capture

Overview:
- Upstream acquisition stage for the oscilloscope LCD display.
- Captures 8-bit ADC samples into a ping-pong sample RAM around a level/edge trigger, with auto-trigger fallback.
- Serves the display's per-column requests with one-cycle read latency (sample value plus out-of-range flag), with horizontal shift applied.
- Swaps banks only at end of a drawn frame, so a frame is never torn.

Parameters:
- DEPTH, 512: samples per bank (power of 2).
- PRE_TRIG, 256: samples kept before the trigger point.
- WIN_START, 106: buffer index shown at screen column 0 when shift is 0.
- AUTO_TIMEOUT, 200000: sample_en strobes in WAIT_TRIG before a forced trigger.

Ports:
- lcd_clk, input, 1: sole clock.
- sys_rst_n, input, 1: asynchronous active-low reset.
- ad_data, input, 8: ADC sample, already synchronous to lcd_clk.
- sample_en, input, 1: one-cycle strobe meaning "ad_data valid, take it" (decimated rate).
- trig_level, input, 8: trigger threshold.
- trig_edge, input, 1: 0 = rising, 1 = falling.
- run, input, 1: 1 = continuous capture, 0 = freeze (finish current frame, then stop).
- h_shift, input, 10: bit9 0/1 = shift left/right; bits[8:0] = column offset.
- data_req, input, 1: display requests data for column line_cnt.
- line_cnt, input, 9: display column 0..299.
- wr_over, input, 1: display finished drawing a frame (one-cycle pulse).
- line_length, output, 16: {8'd0, 255 - sample} for the requested column; valid 1 cycle after the request.
- outrange, output, 1: requested index lies outside the captured buffer; aligned with line_length.
- trig_found, output, 1: 1 when the latest displayed frame was edge-triggered, 0 when it was auto-triggered.

Behaviour:
- Reset values: all outputs 0; state PREFILL; write bank 0; read bank 1 marked empty; counters 0.
- While the read bank is empty, outrange = 1 for every request.
- Write pointer wp is a log2(DEPTH)-bit circular counter. On each sample_en in PREFILL, WAIT_TRIG or POST:
  - write ad_data at wp of the write bank;
  - wp increments and wraps DEPTH-1 -> 0.
- FSM:
  - PREFILL: count PRE_TRIG samples, then go to WAIT_TRIG. prev_sample is tracked from the first sample.
  - WAIT_TRIG: rising trigger = prev < trig_level && cur >= trig_level. Falling trigger = prev >= trig_level && cur < trig_level. Evaluate only on sample_en.
    - On trigger: latch trig_ptr = wp of the triggering sample, set trig_flag = 1, go to POST.
    - If the timeout counter reaches AUTO_TIMEOUT: latch trig_ptr the same way, set trig_flag = 0, go to POST.
    - The timeout counter clears on entry to WAIT_TRIG.
  - POST: write DEPTH-PRE_TRIG samples, with the triggering sample counted as the first. Then go to DONE.
  - DONE: no writes. On wr_over, or immediately if the read bank is empty:
    - swap banks;
    - copy trig_ptr to rd_trig_ptr and trig_flag to trig_found;
    - mark the read bank full;
    - go to PREFILL if run = 1, else STOP.
  - STOP: idle; go to PREFILL when run = 1.
- Simultaneous events:
  - wr_over with sample_en in DONE: the swap wins and that sample is discarded.
  - wr_over outside DONE: ignored.
- Read path:
  - signed index = WIN_START + line_cnt + (h_shift[9] ? -h_shift[8:0] : +h_shift[8:0]), computed at 11-bit signed width.
  - outrange_next = !data_req || index < 0 || index > DEPTH-1 || read bank empty.
  - RAM address = rd_trig_ptr - PRE_TRIG + index, mod DEPTH.
  - Registered RAM output, so latency is exactly 1 lcd_clk.
  - outrange_next is registered to stay aligned with the data.
  - line_length = 255 - sample, so a larger voltage plots higher on screen.
- Reset mid-capture: everything returns to the reset state and the previous frame is lost.
- The display never reads the bank being written.

Decomposition:
- Shared package wave_pkg holds:
  - FSM state enum (PREFILL, WAIT_TRIG, POST, DONE, STOP);
  - DEPTH/PRE_TRIG defaults;
  - display window width 300.
- Sub-module wave_ram: simple dual-port RAM, 2*DEPTH x 8, one write port and one registered read port, with the bank bit as address MSB.

Test Plan:
- Reset, then ramp 0..255 repeating with sample_en every cycle, trig_level = 128, rising edge:
  - required: PREFILL lasts 256 strobes;
  - trigger fires on the first sample >= 128;
  - after the first swap, a request at line_cnt = 150, h_shift = 0 returns line_length = 255 - 128 = 127 one cycle later, with trig_found = 1.
- Constant ad_data = 50, trig_level = 128, AUTO_TIMEOUT = 1000:
  - required: forced trigger after 1000 strobes in WAIT_TRIG;
  - trig_found = 0;
  - all columns return line_length = 205.
- h_shift = {1'b1, 9'd200}, line_cnt = 50: index = -44, so outrange = 1. h_shift = {1'b0, 9'd200}, line_cnt = 299: index = 605, so outrange = 1. h_shift = 0, line_cnt = 0: outrange = 0.
- Capture completes while the display is mid-frame:
  - required: the bank does not swap until the wr_over pulse;
  - data read before wr_over comes from the old frame;
  - data read after wr_over comes from the new frame.
- run = 0 during POST:
  - required: the frame finishes, is swapped on wr_over, and the FSM enters STOP;
  - no further writes occur;
  - run = 1 restarts PREFILL.
- Assert sys_rst_n low during POST:
  - required: outputs 0 immediately (asynchronously);
  - after release, outrange = 1 on every request until the first completed frame.

Source files
------------

// File: rtl/wave_pkg.sv
// ----------------------------------------------------------------------------
// wave_pkg
// Types and defaults shared by the oscilloscope acquisition stage:
//   - wave_state_t : capture sequencer states
//   - DEPTH_DEFAULT / PRE_TRIG_DEFAULT : default bank depth and pre-trigger size
//   - WIN_WIDTH    : number of columns the LCD draws per frame
// ----------------------------------------------------------------------------
package wave_pkg;

    typedef enum logic [2:0] {
        PREFILL   = 3'd0,
        WAIT_TRIG = 3'd1,
        POST      = 3'd2,
        DONE      = 3'd3,
        STOP      = 3'd4
    } wave_state_t;

    localparam int DEPTH_DEFAULT    = 512;
    localparam int PRE_TRIG_DEFAULT = 256;
    localparam int WIN_WIDTH        = 300;

endpackage

// File: rtl/wave_ram.sv
// ----------------------------------------------------------------------------
// wave_ram
// Simple dual-port sample RAM holding both ping-pong banks; the bank select
// is the address MSB. One write port, one read port with a registered output
// (read latency 1 lcd_clk). Contents are not reset.
// Ports:
//   lcd_clk : clock
//   we      : write enable
//   waddr   : write address {bank, index}
//   wdata   : sample to write
//   raddr   : read address {bank, index}
//   rdata   : registered read data
// ----------------------------------------------------------------------------
module wave_ram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          lcd_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge lcd_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wave_capture.sv
// ----------------------------------------------------------------------------
// wave_capture
// Acquisition stage for the oscilloscope LCD. Captures ADC samples into the
// write bank around a level/edge trigger (auto-trigger after AUTO_TIMEOUT
// strobes), and serves per-column display reads from the other bank with a
// one-cycle latency. Banks swap only when the display finishes a frame, or
// immediately if nothing has been shown yet.
// Ports:
//   lcd_clk, sys_rst_n      : clock, asynchronous active-low reset
//   ad_data, sample_en      : ADC sample and its take-it strobe
//   trig_level, trig_edge   : threshold and edge (0 rising, 1 falling)
//   run                     : 1 continuous capture, 0 stop after this frame
//   h_shift                 : bit9 direction (1 = subtract), bits[8:0] offset
//   data_req, line_cnt      : display column request
//   wr_over                 : display finished drawing a frame
//   line_length             : {8'd0, 255 - sample}, 0 when out of range
//   outrange                : requested index has no captured sample
//   trig_found              : displayed frame was edge-triggered
// ----------------------------------------------------------------------------
module wave_capture
    import wave_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int PRE_TRIG     = PRE_TRIG_DEFAULT,
    parameter int WIN_START    = 106,
    parameter int AUTO_TIMEOUT = 200000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ad_data,
    input  logic        sample_en,
    input  logic [7:0]  trig_level,
    input  logic        trig_edge,
    input  logic        run,
    input  logic [9:0]  h_shift,
    input  logic        data_req,
    input  logic [8:0]  line_cnt,
    input  logic        wr_over,
    output logic [15:0] line_length,
    output logic        outrange,
    output logic        trig_found
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int TW       = $clog2(AUTO_TIMEOUT + 1);
    localparam int IW       = 11;
    localparam int POST_LEN = DEPTH - PRE_TRIG;

    localparam logic signed [IW-1:0] WIN_START_S = IW'(WIN_START);
    localparam logic signed [IW-1:0] IDX_MAX     = IW'(DEPTH - 1);

    wave_state_t   state_reg;
    logic [AW-1:0] wp_reg;
    logic [AW-1:0] trig_ptr_reg;
    logic [AW-1:0] rd_trig_ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic [TW-1:0] tmo_reg;
    logic [7:0]    prev_reg;
    logic          trig_flag_reg;
    logic          wr_bank_reg;
    logic          rd_full_reg;
    logic          trig_found_reg;
    logic          outrange_reg;
    logic          rd_valid_reg;

    logic          capturing;
    logic          ram_we;
    logic          edge_hit;
    logic          swap;

    logic signed [IW-1:0] shift_mag;
    logic signed [IW-1:0] idx;
    logic [AW-1:0]        rd_addr;
    logic                 outrange_next;
    logic [7:0]           rd_data;

    assign capturing = (state_reg == PREFILL) || (state_reg == WAIT_TRIG) ||
                       (state_reg == POST);
    assign ram_we    = sample_en && capturing;

    // Only meaningful in WAIT_TRIG; prev_reg holds the last written sample.
    always_comb begin
        if (trig_edge) begin
            edge_hit = (prev_reg >= trig_level) && (ad_data < trig_level);
        end else begin
            edge_hit = (prev_reg < trig_level) && (ad_data >= trig_level);
        end
    end

    // A finished frame goes straight to the display if it has nothing yet.
    assign swap = (state_reg == DONE) && (wr_over || !rd_full_reg);

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= PREFILL;
            wp_reg          <= '0;
            trig_ptr_reg    <= '0;
            rd_trig_ptr_reg <= '0;
            cnt_reg         <= '0;
            tmo_reg         <= '0;
            prev_reg        <= '0;
            trig_flag_reg   <= 1'b0;
            wr_bank_reg     <= 1'b0;
            rd_full_reg     <= 1'b0;
            trig_found_reg  <= 1'b0;
        end else begin
            if (ram_we) begin
                wp_reg   <= wp_reg + 1'b1;
                prev_reg <= ad_data;
            end
            case (state_reg)
                PREFILL: begin
                    if (sample_en) begin
                        if (cnt_reg == CW'(PRE_TRIG - 1)) begin
                            cnt_reg   <= '0;
                            tmo_reg   <= '0;
                            state_reg <= WAIT_TRIG;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (sample_en) begin
                        // A real edge on the timeout strobe still counts as a trigger.
                        if (edge_hit || (tmo_reg == TW'(AUTO_TIMEOUT - 1))) begin
                            trig_ptr_reg  <= wp_reg;
                            trig_flag_reg <= edge_hit;
                            cnt_reg       <= CW'(1);
                            state_reg     <= (POST_LEN == 1) ? DONE : POST;
                        end else begin
                            tmo_reg <= tmo_reg + 1'b1;
                        end
                    end
                end
                POST: begin
                    if (sample_en) begin
                        if (cnt_reg == CW'(POST_LEN - 1)) begin
                            cnt_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (swap) begin
                        wr_bank_reg     <= ~wr_bank_reg;
                        rd_trig_ptr_reg <= trig_ptr_reg;
                        trig_found_reg  <= trig_flag_reg;
                        rd_full_reg     <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= run ? PREFILL : STOP;
                    end
                end
                STOP: begin
                    if (run) begin
                        cnt_reg   <= '0;
                        state_reg <= PREFILL;
                    end
                end
                default: state_reg <= PREFILL;
            endcase
        end
    end

    // Screen column -> buffer index (0 = oldest pre-trigger sample).
    always_comb begin
        shift_mag = $signed({2'b00, h_shift[8:0]});
        if (h_shift[9]) begin
            shift_mag = -shift_mag;
        end
        idx = WIN_START_S + $signed({2'b00, line_cnt}) + shift_mag;
        outrange_next = !data_req || idx[IW-1] || (idx > IDX_MAX) || !rd_full_reg;
        rd_addr = rd_trig_ptr_reg - AW'(PRE_TRIG) + idx[AW-1:0];
    end

    wave_ram #(
        .AW (AW + 1),
        .DW (8)
    ) u_ram (
        .lcd_clk (lcd_clk),
        .we      (ram_we),
        .waddr   ({wr_bank_reg, wp_reg}),
        .wdata   (ad_data),
        .raddr   ({~wr_bank_reg, rd_addr}),
        .rdata   (rd_data)
    );

    // Flags registered alongside the RAM read so they line up with rd_data.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            outrange_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            outrange_reg <= outrange_next;
            rd_valid_reg <= !outrange_next;
        end
    end

    assign line_length = rd_valid_reg ? {8'd0, 8'd255 - rd_data} : 16'd0;
    assign outrange    = outrange_reg;
    assign trig_found  = trig_found_reg;

endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;

    localparam int DEPTH = 512;
    localparam int PRE   = 256;
    localparam int POSTN = 256;
    localparam int WIN   = 106;
    localparam int TMO   = 1000;

    logic        lcd_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  ad_data = 8'd0;
    logic        sample_en = 1'b0;
    logic [7:0]  trig_level = 8'd128;
    logic        trig_edge = 1'b0;
    logic        run = 1'b1;
    logic [9:0]  h_shift = 10'd0;
    logic        data_req = 1'b0;
    logic [8:0]  line_cnt = 9'd0;
    logic        wr_over = 1'b0;
    logic [15:0] line_length;
    logic        outrange;
    logic        trig_found;

    wave_capture #(
        .DEPTH        (DEPTH),
        .PRE_TRIG     (PRE),
        .WIN_START    (WIN),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .lcd_clk     (lcd_clk),
        .sys_rst_n   (sys_rst_n),
        .ad_data     (ad_data),
        .sample_en   (sample_en),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .run         (run),
        .h_shift     (h_shift),
        .data_req    (data_req),
        .line_cnt    (line_cnt),
        .wr_over     (wr_over),
        .line_length (line_length),
        .outrange    (outrange),
        .trig_found  (trig_found)
    );

    always #5 lcd_clk = ~lcd_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the sample stream of the frame being captured and of
    // the frame on display, plus the strobe index of each trigger.
    int gen  [0:2047];
    int gen_len;
    int gen_k;
    bit gen_flag;
    int disp [0:2047];
    int disp_k;
    bit disp_flag;
    bit disp_valid;
    bit use_gaps;

    typedef struct {
        int         line;
        logic [9:0] sh;
        bit         exp_or;
        int         exp_idx;
    } win_vec_t;

    win_vec_t tbl [10];

    task automatic tick();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Generate a frame's stream and locate its trigger from the rules alone.
    task automatic build_frame(input int mode, input int lvl, input bit fall);
        int maxn;
        bit hit;
        maxn = PRE + TMO + POSTN;
        for (int j = 0; j < maxn; j++) begin
            case (mode)
                0:       gen[j] = 50;
                1:       gen[j] = j % 256;
                default: gen[j] = int'($urandom_range(0, 255));
            endcase
        end
        gen_k = -1;
        gen_flag = 1'b0;
        for (int j = PRE; j < PRE + TMO; j++) begin
            if (gen_k < 0) begin
                hit = fall ? (gen[j-1] >= lvl && gen[j] < lvl)
                           : (gen[j-1] < lvl && gen[j] >= lvl);
                if (hit) begin
                    gen_k = j;
                    gen_flag = 1'b1;
                end else if (j - PRE + 1 == TMO) begin
                    gen_k = j;
                    gen_flag = 1'b0;
                end
            end
        end
        gen_len = gen_k + POSTN;
        trig_level = 8'(lvl);
        trig_edge = fall;
        $display("frame mode=%0d level=%0d edge=%0b trigger_strobe=%0d edge_trig=%0b strobes=%0d",
                 mode, lvl, fall, gen_k, gen_flag, gen_len);
    endtask

    task automatic drive_strobes(input int from, input int to);
        for (int j = from; j < to; j++) begin
            ad_data = 8'(gen[j]);
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            if (use_gaps) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic promote();
        for (int j = 0; j < gen_len; j++) disp[j] = gen[j];
        disp_k = gen_k;
        disp_flag = gen_flag;
        disp_valid = 1'b1;
    endtask

    task automatic read_col(input int line, input logic [9:0] sh,
                            output bit o, output int ll, output bit tf);
        data_req = 1'b1;
        line_cnt = 9'(line);
        h_shift = sh;
        tick();
        o = outrange;
        ll = int'(line_length);
        tf = trig_found;
        data_req = 1'b0;
        $display("read line=%0d shift=%0b/%0d -> line_length=%0d outrange=%0b trig_found=%0b",
                 line, sh[9], sh[8:0], ll, o, tf);
    endtask

    task automatic check_col(input int line, input logic [9:0] sh, input string tag);
        int idx;
        bit exp_or;
        bit o;
        bit tf;
        int ll;
        idx = WIN + line + (sh[9] ? -int'(sh[8:0]) : int'(sh[8:0]));
        exp_or = !disp_valid || idx < 0 || idx > DEPTH - 1;
        read_col(line, sh, o, ll, tf);
        check({tag, "_outrange"}, int'(o), int'(exp_or));
        if (!exp_or) check({tag, "_line_length"}, ll, 255 - disp[disp_k - PRE + idx]);
        check({tag, "_trig_found"}, int'(tf), disp_valid ? int'(disp_flag) : 0);
    endtask

    task automatic random_cols(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_col(int'($urandom_range(0, 299)), 10'($urandom), tag);
        end
    endtask

    task automatic run_table(input string tag);
        bit o;
        bit tf;
        int ll;
        bit exp_or;
        for (int i = 0; i < 10; i++) begin
            read_col(tbl[i].line, tbl[i].sh, o, ll, tf);
            exp_or = tbl[i].exp_or || !disp_valid;
            check({tag, "_outrange"}, int'(o), int'(exp_or));
            if (!exp_or) check({tag, "_line_length"}, ll, 255 - disp[disp_k - PRE + tbl[i].exp_idx]);
        end
    endtask

    initial begin
        tbl[0] = '{50,  10'd712,  1'b1, -44};
        tbl[1] = '{299, 10'd200,  1'b1, 605};
        tbl[2] = '{0,   10'd0,    1'b0, 106};
        tbl[3] = '{150, 10'd0,    1'b0, 256};
        tbl[4] = '{0,   10'd618,  1'b0, 0};
        tbl[5] = '{0,   10'd619,  1'b1, -1};
        tbl[6] = '{299, 10'd106,  1'b0, 511};
        tbl[7] = '{299, 10'd107,  1'b1, 512};
        tbl[8] = '{299, 10'd1023, 1'b1, -106};
        tbl[9] = '{10,  10'd517,  1'b0, 111};
        disp_valid = 1'b0;
        use_gaps = 1'b0;

        // Reset state
        sys_rst_n = 1'b0;
        repeat (3) tick();
        check("reset_line_length", int'(line_length), 0);
        check("reset_outrange", int'(outrange), 0);
        check("reset_trig_found", int'(trig_found), 0);
        sys_rst_n = 1'b1;
        tick();
        check_col(0, 10'd0, "empty");

        // Auto-trigger frame: bank must stay empty until the very last strobe
        build_frame(0, 128, 1'b0);
        use_gaps = 1'b1;
        drive_strobes(0, gen_len - 1);
        repeat (3) tick();
        check_col(0, 10'd0, "auto_before_last");
        drive_strobes(gen_len - 1, gen_len);
        repeat (2) tick();
        promote();
        check_col(150, 10'd0, "auto150");
        run_table("auto_tbl");
        tick();
        check("noreq_outrange", int'(outrange), 1);

        // Ramp frame completes while the display is mid-frame
        build_frame(1, 128, 1'b0);
        use_gaps = 1'b0;
        drive_strobes(0, gen_len);
        repeat (4) tick();
        run_table("old_frame_tbl");
        ad_data = 8'd7;
        sample_en = 1'b1;
        tick();
        ad_data = 8'd9;
        wr_over = 1'b1;
        tick();
        sample_en = 1'b0;
        wr_over = 1'b0;
        promote();
        tick();
        check_col(150, 10'd0, "ramp150");
        run_table("ramp_tbl");

        // Random frame, run dropped during POST -> STOP after the swap
        build_frame(2, int'($urandom_range(1, 254)), 1'($urandom_range(0, 1)));
        use_gaps = 1'b1;
        drive_strobes(0, gen_k + 10);
        run = 1'b0;
        drive_strobes(gen_k + 10, gen_len);
        repeat (3) tick();
        random_cols(4, "before_wr_over");
        wr_over = 1'b1;
        tick();
        wr_over = 1'b0;
        promote();
        tick();
        random_cols(12, "rand_frame");
        run_table("rand_tbl");
        for (int i = 0; i < 600; i++) begin
            ad_data = 8'($urandom);
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
        end
        run = 1'b1;
        repeat (2) tick();

        // Restart: a fresh frame must need its full strobe count again
        build_frame(1, 128, 1'b0);
        drive_strobes(0, gen_len - 1);
        wr_over = 1'b1;
        tick();
        wr_over = 1'b0;
        tick();
        random_cols(6, "early_wr_over");
        drive_strobes(gen_len - 1, gen_len);
        repeat (3) tick();
        random_cols(4, "done_waiting");
        wr_over = 1'b1;
        tick();
        wr_over = 1'b0;
        promote();
        tick();
        check_col(150, 10'd0, "restart150");
        run_table("restart_tbl");

        // Reset during POST
        build_frame(1, 128, 1'b0);
        use_gaps = 1'b0;
        drive_strobes(0, gen_k + 50);
        data_req = 1'b1;
        line_cnt = 9'd50;
        h_shift = 10'd712;
        tick();
        check("pre_reset_outrange", int'(outrange), 1);
        check("pre_reset_trig_found", int'(trig_found), 1);
        #3 sys_rst_n = 1'b0;
        #1;
        check("async_reset_line_length", int'(line_length), 0);
        check("async_reset_outrange", int'(outrange), 0);
        check("async_reset_trig_found", int'(trig_found), 0);
        data_req = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        disp_valid = 1'b0;
        tick();
        run_table("after_reset_tbl");

        // First frame after reset
        build_frame(2, int'($urandom_range(1, 254)), 1'($urandom_range(0, 1)));
        use_gaps = 1'b1;
        drive_strobes(0, gen_len - 1);
        repeat (2) tick();
        check_col(0, 10'd0, "post_reset_before_last");
        drive_strobes(gen_len - 1, gen_len);
        repeat (2) tick();
        promote();
        random_cols(10, "post_reset_frame");
        run_table("post_reset_tbl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
